// File: rtl/filter_mac_scheduler.sv
// Sequencer that time-shares one MAC across two channels (L/R) and three filters
// (LPF/BPF/HPF), producing tap/coef addresses, MAC controls and result-write strobes.
module filter_mac_scheduler #(
  parameter int N_TAPS  = 16,
  parameter int TAP_AW  = 4,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shot_L,
  input  logic              shot_R,
  output logic [TAP_AW-1:0] tap_addr,
  output logic [TAP_AW+1:0] coef_addr,
  output logic [1:0]        filter_sel,
  output logic              chan_sel,
  output logic              mac_clear,
  output logic              mac_en,
  output logic              result_we,
  output logic              done_L,
  output logic              done_R,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, WRITE} state_t;

  localparam logic [TAP_AW-1:0] TAP_LAST = TAP_AW'(N_TAPS - 1);
  localparam logic [2:0]        LAT_LAST = 3'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  state_t            state_reg, state_next;
  logic [TAP_AW-1:0] tap_reg, tap_next;
  logic [1:0]        filt_reg, filt_next;
  logic              chan_reg, chan_next;
  logic [2:0]        lat_reg, lat_next;
  logic [1:0]        shot_vec, pend_reg, pend_next, consume, drop;
  logic [1:0]        done_reg, done_next;
  logic              overrun_reg;
  logic              clear_reg, en_reg, we_reg, busy_reg;

  assign shot_vec = {shot_R, shot_L};

  // Per-channel request bookkeeping; index 0 = L, 1 = R.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      // A shot landing on the edge its pending job is taken is simply re-queued.
      assign drop[gi]      = shot_vec[gi] & pend_reg[gi] & ~consume[gi];
      assign pend_next[gi] = shot_vec[gi] | (pend_reg[gi] & ~consume[gi]);
      assign done_next[gi] = (state_reg == WRITE) && (filt_reg == 2'd2) &&
                             (chan_reg == 1'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    tap_next   = tap_reg;
    filt_next  = filt_reg;
    chan_next  = chan_reg;
    lat_next   = lat_reg;
    consume    = 2'b00;
    case (state_reg)
      IDLE: begin
        if (pend_reg != 2'b00) begin
          state_next = CLEAR;
          filt_next  = 2'd0;
          chan_next  = ~pend_reg[0];
          consume    = pend_reg[0] ? 2'b01 : 2'b10;
        end
      end
      CLEAR: begin
        tap_next   = '0;
        state_next = RUN;
      end
      RUN: begin
        if (tap_reg == TAP_LAST) begin
          lat_next   = 3'd0;
          state_next = (MAC_LAT == 0) ? WRITE : DRAIN;
        end else begin
          tap_next = tap_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (lat_reg == LAT_LAST) state_next = WRITE;
        else                     lat_next   = lat_reg + 3'd1;
      end
      WRITE: begin
        if (filt_reg != 2'd2) begin
          filt_next  = filt_reg + 2'd1;
          state_next = CLEAR;
        end else if (pend_reg[~chan_reg]) begin
          // Hand over straight to the other channel without passing through IDLE.
          chan_next  = ~chan_reg;
          filt_next  = 2'd0;
          state_next = CLEAR;
          consume    = chan_reg ? 2'b01 : 2'b10;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      tap_reg     <= '0;
      filt_reg    <= 2'd0;
      chan_reg    <= 1'b0;
      lat_reg     <= 3'd0;
      pend_reg    <= 2'b00;
      overrun_reg <= 1'b0;
      done_reg    <= 2'b00;
      clear_reg   <= 1'b0;
      en_reg      <= 1'b0;
      we_reg      <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tap_reg     <= tap_next;
      filt_reg    <= filt_next;
      chan_reg    <= chan_next;
      lat_reg     <= lat_next;
      pend_reg    <= pend_next;
      overrun_reg <= overrun_reg | (|drop);
      done_reg    <= done_next;
      clear_reg   <= (state_next == CLEAR);
      en_reg      <= (state_next == RUN);
      we_reg      <= (state_next == WRITE);
      busy_reg    <= (state_next != IDLE);
    end
  end

  assign tap_addr   = tap_reg;
  assign coef_addr  = {filt_reg, tap_reg};
  assign filter_sel = filt_reg;
  assign chan_sel   = chan_reg;
  assign mac_clear  = clear_reg;
  assign mac_en     = en_reg;
  assign result_we  = we_reg;
  assign done_L     = done_reg[0];
  assign done_R     = done_reg[1];
  assign busy       = busy_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_filter_mac_scheduler.sv
// Checks two scheduler configurations (defaults, and N_TAPS=2/MAC_LAT=0) against a
// job-timeline model: each output is derived from the cycle offset inside the current job.
module tb_filter_mac_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] sh0, sh1;   // {shot_R, shot_L} per instance

  wire [3:0] tap0, tap1;
  wire [5:0] coef0, coef1;
  wire [1:0] fs0, fs1;
  wire cs0, clr0, en0, we0, dl0, dr0, bz0, ov0;
  wire cs1, clr1, en1, we1, dl1, dr1, bz1, ov1;

  filter_mac_scheduler dut0 (
    .clk(clk), .reset(reset), .shot_L(sh0[0]), .shot_R(sh0[1]),
    .tap_addr(tap0), .coef_addr(coef0), .filter_sel(fs0), .chan_sel(cs0),
    .mac_clear(clr0), .mac_en(en0), .result_we(we0), .done_L(dl0), .done_R(dr0),
    .busy(bz0), .overrun(ov0)
  );

  filter_mac_scheduler #(.N_TAPS(2), .TAP_AW(4), .MAC_LAT(0)) dut1 (
    .clk(clk), .reset(reset), .shot_L(sh1[0]), .shot_R(sh1[1]),
    .tap_addr(tap1), .coef_addr(coef1), .filter_sel(fs1), .chan_sel(cs1),
    .mac_clear(clr1), .mac_en(en1), .result_we(we1), .done_L(dl1), .done_R(dr1),
    .busy(bz1), .overrun(ov1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic string tg(input int u, input string s);
    return $sformatf("u%0d@%0d %s", u, cyc, s);
  endfunction

  // Reference model: one job = 3 blocks of (1 clear + N taps + L drain + 1 write).
  int       m_n[2] = '{16, 2};
  int       m_l[2] = '{2, 0};
  bit       m_act[2];
  bit       m_chan[2];
  int       m_k[2];
  bit [1:0] m_pend[2];
  bit       m_ovr[2];
  bit [1:0] m_done[2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_act[u] = 0; m_chan[u] = 0; m_k[u] = 0;
      m_pend[u] = 2'b00; m_ovr[u] = 0; m_done[u] = 2'b00;
    end
  endtask

  task automatic model_step(input int u, input logic [1:0] sh);
    int       b, j;
    bit [1:0] cons;
    b = m_n[u] + m_l[u] + 2;
    j = 3 * b;
    cons = 2'b00;
    m_done[u] = 2'b00;
    if (m_act[u]) begin
      if (m_k[u] == j - 1) begin
        m_done[u][m_chan[u]] = 1'b1;
        if (m_pend[u][!m_chan[u]]) begin
          m_chan[u] = !m_chan[u];
          m_k[u] = 0;
          cons[m_chan[u]] = 1'b1;
        end else begin
          m_act[u] = 0;
        end
      end else begin
        m_k[u]++;
      end
    end else if (m_pend[u] != 2'b00) begin
      m_act[u] = 1;
      m_k[u] = 0;
      m_chan[u] = m_pend[u][0] ? 1'b0 : 1'b1;
      cons[m_chan[u]] = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      if (sh[c] && m_pend[u][c] && !cons[c]) m_ovr[u] = 1;
      m_pend[u][c] = sh[c] | (m_pend[u][c] & !cons[c]);
    end
  endtask

  task automatic compare_inst(input int u);
    logic [3:0] tap; logic [5:0] coef; logic [1:0] fs;
    logic cs, clr, en, we, dl, dr, bz, ov;
    int b, off, blk;
    bit act, exp_en;
    if (u == 0) begin
      tap = tap0; coef = coef0; fs = fs0; cs = cs0; clr = clr0; en = en0;
      we = we0; dl = dl0; dr = dr0; bz = bz0; ov = ov0;
    end else begin
      tap = tap1; coef = coef1; fs = fs1; cs = cs1; clr = clr1; en = en1;
      we = we1; dl = dl1; dr = dr1; bz = bz1; ov = ov1;
    end
    b = m_n[u] + m_l[u] + 2;
    off = m_k[u] % b;
    blk = m_k[u] / b;
    act = m_act[u];
    exp_en = act && off >= 1 && off <= m_n[u];
    check_val(tg(u, "busy"), bz, act);
    check_val(tg(u, "mac_clear"), clr, act && off == 0);
    check_val(tg(u, "mac_en"), en, exp_en);
    check_val(tg(u, "result_we"), we, act && off == m_n[u] + m_l[u] + 1);
    check_val(tg(u, "done_L"), dl, m_done[u][0]);
    check_val(tg(u, "done_R"), dr, m_done[u][1]);
    check_val(tg(u, "overrun"), ov, m_ovr[u]);
    check_val(tg(u, "chan_sel"), cs, m_chan[u]);
    if (act) check_val(tg(u, "filter_sel"), fs, blk);
    if (exp_en) begin
      check_val(tg(u, "tap_addr"), tap, off - 1);
      check_val(tg(u, "coef_addr"), coef, blk * 16 + off - 1);
    end
  endtask

  task automatic zero_check(input string s);
    check_val({s, " u0 outs"}, {tap0, coef0, fs0, cs0, clr0, en0, we0, dl0, dr0, bz0, ov0}, 0);
    check_val({s, " u1 outs"}, {tap1, coef1, fs1, cs1, clr1, en1, we1, dl1, dr1, bz1, ov1}, 0);
  endtask

  task automatic tick(input logic [1:0] s0, input logic [1:0] s1);
    sh0 = s0;
    sh1 = s1;
    @(posedge clk);
    cyc++;
    model_step(0, s0);
    model_step(1, s1);
    @(negedge clk);
    compare_inst(0);
    compare_inst(1);
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    zero_check("async_rst");
    repeat (2) @(negedge clk);
    zero_check("rst_hold");
    sh0 = 2'b00;
    sh1 = 2'b00;
    reset = 1'b1;
  endtask

  function automatic logic [1:0] rand_shots();
    return {1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 29) == 0)};
  endfunction

  initial begin
    model_reset();
    reset = 1'b0;
    sh0 = 2'b01;   // shot_L held during reset must not leave a pending request
    sh1 = 2'b01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_check("por");
    sh0 = 2'b00;
    sh1 = 2'b00;
    reset = 1'b1;
    repeat (5) tick(2'b00, 2'b00);

    // Single left request
    tick(2'b01, 2'b01);
    repeat (70) tick(2'b00, 2'b00);

    // Simultaneous left and right requests
    tick(2'b11, 2'b11);
    repeat (130) tick(2'b00, 2'b00);

    // Right queued at cycle 30, repeated at cycle 40 while still pending
    tick(2'b01, 2'b01);
    repeat (29) tick(2'b00, 2'b00);
    tick(2'b10, 2'b10);
    repeat (9) tick(2'b00, 2'b00);
    tick(2'b10, 2'b10);
    repeat (100) tick(2'b00, 2'b00);

    // Reset mid-RUN
    tick(2'b01, 2'b01);
    repeat (10) tick(2'b00, 2'b00);
    async_reset();
    repeat (20) tick(2'b00, 2'b00);

    // Randomized requests with periodic asynchronous resets
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 1500; i++) tick(rand_shots(), rand_shots());
      async_reset();
      repeat (3) tick(2'b00, 2'b00);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
